// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with a 2-entry skid
// buffer. in_ready, out_valid and out_data all come straight from flops, so
// back-pressure never forms a combinational path across the stage boundary.
module pipe_stage_reg #(
  parameter int WIDTH          = 32,
  parameter bit ZERO_ON_BUBBLE = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             consume;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // Occupancy FSM; out_valid/in_ready are registered copies of (state!=EMPTY)
  // and (state!=FULL), updated together with the state so they never diverge.
  // out_data is the main register itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Flush wins over everything: held beats and the offered beat die.
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      if (ZERO_ON_BUBBLE) begin
        out_data <= '0;
        skid_q   <= '0;
      end
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            state     <= S_ONE;
            out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            // Pass-through at full rate: main simply takes the new beat.
            out_data <= in_data;
          end else if (consume) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            if (ZERO_ON_BUBBLE) out_data <= '0;
          end else if (accept) begin
            // Downstream stalled: park the beat in skid, drop in_ready.
            skid_q   <= in_data;
            state    <= S_FULL;
            in_ready <= 1'b0;
          end
        end
        S_FULL: begin
          // No accept possible here; skid drains into main on consume.
          if (consume) begin
            out_data <= skid_q;
            state    <= S_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Saturating back-pressure counter; only reset clears it, flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue-based occupancy model checked every
// cycle, plus directed vectors with literal expectations.
module tb_pipe_stage_reg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  bit saw_c = 1'b0;

  pipe_stage_reg #(.WIDTH(WIDTH), .ZERO_ON_BUBBLE(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most 2 beats; bubbles read as zero.
  logic [WIDTH-1:0] mq[$];
  int               mcnt = 0;

  // Falling edge: compare against model, then advance the model with the
  // inputs that will be seen at the coming rising edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_d;
    bit acc, con;
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end
    exp_d = (mq.size() > 0) ? mq[0] : '0;
    check("m_out_valid", out_valid, mq.size() > 0);
    check("m_in_ready", in_ready, mq.size() < 2);
    check("m_out_data", out_data, exp_d);
    check("m_stall_cnt", stall_cnt, mcnt);
    if (out_valid && out_ready && out_data == 32'hC) saw_c = 1'b1;
    if (!rst) begin
      acc = in_valid && (mq.size() < 2);
      con = (mq.size() > 0) && out_ready;
      if (mq.size() > 0 && !out_ready && mcnt < CMAX) mcnt++;
      if (flush) mq.delete();
      else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input bit ov, input bit ir,
                            input logic [WIDTH-1:0] od);
    check({name, ".out_valid"}, out_valid, ov);
    check({name, ".in_ready"}, in_ready, ir);
    check({name, ".out_data"}, out_data, od);
  endtask

  initial begin
    // Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); in_data = $urandom;
      out_ready = 1'($urandom); flush = 1'($urandom);
      step();
      expect_out("reset", 1'b0, 1'b1, '0);
      check("reset.stall_cnt", stall_cnt, 0);
    end
    rst = 0; in_valid = 0; out_ready = 0; flush = 0; in_data = '0;
    step();

    // Streaming 1..8 with downstream always ready.
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1; in_data = k;
      step();
      expect_out("stream", 1'b1, 1'b1, k);
    end
    in_valid = 0;
    step();
    expect_out("stream_end", 1'b0, 1'b1, '0);
    check("stream.stall_cnt", stall_cnt, 0);

    // Skid fill: 0xA, 0xB with downstream stalled.
    out_ready = 0; in_valid = 1; in_data = 32'hA;
    step();
    expect_out("fill_a", 1'b1, 1'b1, 32'hA);
    in_data = 32'hB;
    step();
    expect_out("fill_b", 1'b1, 1'b0, 32'hA);
    in_data = 32'hEE;   // offered while not ready: must be ignored
    step();
    expect_out("fill_hold", 1'b1, 1'b0, 32'hA);
    check("fill.stall_cnt", stall_cnt, 2);
    in_valid = 0; out_ready = 1;
    step();
    expect_out("drain_b", 1'b1, 1'b1, 32'hB);
    step();
    expect_out("drain_end", 1'b0, 1'b1, '0);
    check("drain.stall_cnt", stall_cnt, 2);

    // Flush in FULL with a beat offered in the same cycle.
    out_ready = 0; in_valid = 1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    expect_out("pre_flush", 1'b1, 1'b0, 32'hA);
    flush = 1; in_valid = 1; in_data = 32'hC;
    step();
    expect_out("flush", 1'b0, 1'b1, '0);
    check("flush.stall_cnt", stall_cnt, 4);
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    step();
    expect_out("post_flush", 1'b0, 1'b1, '0);
    check("flush.no_c", saw_c, 0);

    // Flush together with a consume in ONE.
    in_valid = 1; in_data = 32'h77;
    step();
    in_valid = 0; flush = 1;
    step();
    expect_out("flush_consume", 1'b0, 1'b1, '0);
    flush = 0;

    // Saturation of the 3-bit counter, then flush must not clear it.
    out_ready = 0; in_valid = 1; in_data = 32'h55;
    step();
    in_valid = 0;
    repeat (12) step();
    check("sat.stall_cnt", stall_cnt, CMAX);
    expect_out("sat", 1'b1, 1'b1, 32'h55);
    flush = 1;
    step();
    flush = 0;
    check("sat_flush.stall_cnt", stall_cnt, CMAX);
    expect_out("sat_flush", 1'b0, 1'b1, '0);

    // Asynchronous reset between edges while FULL.
    in_valid = 1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_valid = 0;
    expect_out("pre_arst", 1'b1, 1'b0, 32'h11);
    #2 rst = 1;
    #1;
    expect_out("arst", 1'b0, 1'b1, '0);
    check("arst.stall_cnt", stall_cnt, 0);
    step();
    step();
    rst = 0;
    step();
    expect_out("post_arst", 1'b0, 1'b1, '0);

    // Mixed traffic, checked by the per-cycle model.
    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      out_ready = 1'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      step();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) step();
    expect_out("final", 1'b0, 1'b1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
